// File: rtl/logic_shift_reg_pkg.sv
// Shared encodings for the logic/shift register slice.
// Op codes select the bitwise function; mode codes select register update.
package logic_shift_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

endpackage

// File: rtl/logic_shift_reg_fn.sv
// Combinational bitwise function unit.
// Pure per-bit logic, no carry between bits.
module logic_fn
    import logic_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] f
);

    always_comb begin
        f = '0;
        case (op)
            OP_AND:  f = in1 & in2;
            OP_OR:   f = in1 | in2;
            OP_XOR:  f = in1 ^ in2;
            OP_NAND: f = ~(in1 & in2);
            OP_NOR:  f = ~(in1 | in2);
            OP_XNOR: f = ~(in1 ^ in2);
            OP_NOT:  f = ~in1;
            OP_PASS: f = in1;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/logic_shift_reg.sv
// Logic unit feeding a hold/load/shift register with a delayed copy,
// serial shift-out bit and zero flag.
module logic_shift_reg
    import logic_shift_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       op,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_dly,
    output logic             ser_out,
    output logic             zero
);

    logic [WIDTH-1:0] dly [STAGES];

    logic_fn #(.WIDTH(WIDTH)) u_fn (
        .in1 (in1),
        .in2 (in2),
        .op  (op),
        .f   (f)
    );

    assign out1  = in1 ^ in2;
    assign out2  = out1 & in2;
    assign zero  = (q == '0);
    assign q_dly = dly[STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            q       <= '0;
            ser_out <= 1'b0;
        end else if (en) begin
            case (mode)
                MODE_LOAD: q <= f;
                MODE_SHL: begin
                    q       <= {q[WIDTH-2:0], ser_in};
                    ser_out <= q[WIDTH-1];
                end
                MODE_SHR: begin
                    q       <= {ser_in, q[WIDTH-1:1]};
                    ser_out <= q[0];
                end
                default: q <= q;
            endcase
        end
    end

    // Delay line runs every edge, independent of en.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++)
                dly[i] <= '0;
        end else begin
            dly[0] <= q;
            for (int i = 1; i < STAGES; i++)
                dly[i] <= dly[i-1];
        end
    end

endmodule

// File: tb/tb_logic_shift_reg.sv
// Directed bench for logic_shift_reg at WIDTH=8, STAGES=2.
module tb_logic_shift_reg;

    logic       clk;
    logic       rst;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [2:0] op;
    logic [1:0] mode;
    logic       en;
    logic       ser_in;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] f;
    logic [7:0] q;
    logic [7:0] q_dly;
    logic       ser_out;
    logic       zero;

    int checks   = 0;
    int failures = 0;

    logic_shift_reg #(.WIDTH(8), .STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .in1     (in1),
        .in2     (in2),
        .op      (op),
        .mode    (mode),
        .en      (en),
        .ser_in  (ser_in),
        .out1    (out1),
        .out2    (out2),
        .f       (f),
        .q       (q),
        .q_dly   (q_dly),
        .ser_out (ser_out),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; mode = 2'b01; op = 3'b111;
        in1 = 8'hFF; in2 = 8'h00; ser_in = 1'b0;
        tick();
        tick();
        checks++;
        if (q !== 8'h00) begin
            failures++;
            $display("FAIL reset_q got=%h exp=00", q);
        end
        checks++;
        if (q_dly !== 8'h00) begin
            failures++;
            $display("FAIL reset_qdly got=%h exp=00", q_dly);
        end
        checks++;
        if (ser_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_ser got=%b exp=0", ser_out);
        end
        checks++;
        if (zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_zero got=%b exp=1", zero);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (q !== 8'hFF) begin
            failures++;
            $display("FAIL release_q got=%h exp=ff", q);
        end
        checks++;
        if (zero !== 1'b0) begin
            failures++;
            $display("FAIL release_zero got=%b exp=0", zero);
        end
    endtask

    task automatic test_op_sweep();
        logic [7:0] exp_q [8];
        exp_q[0] = 8'h81; exp_q[1] = 8'hE7;
        exp_q[2] = 8'h66; exp_q[3] = 8'h7E;
        exp_q[4] = 8'h18; exp_q[5] = 8'h99;
        exp_q[6] = 8'h3C; exp_q[7] = 8'hC3;
        in1 = 8'hC3; in2 = 8'hA5; mode = 2'b01; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            #1;
            checks++;
            if (f !== exp_q[i]) begin
                failures++;
                $display("FAIL op%0d_f got=%h exp=%h", i, f, exp_q[i]);
            end
            tick();
            checks++;
            if (q !== exp_q[i]) begin
                failures++;
                $display("FAIL op%0d_q got=%h exp=%h", i, q, exp_q[i]);
            end
            checks++;
            if (out1 !== 8'h66 || out2 !== 8'h24) begin
                failures++;
                $display("FAIL op%0d_out got=%h/%h exp=66/24", i, out1, out2);
            end
        end
    endtask

    task automatic test_shift_left();
        logic [7:0] exp_q [3];
        logic       exp_s [3];
        exp_q[0] = 8'h03; exp_q[1] = 8'h07; exp_q[2] = 8'h0F;
        exp_s[0] = 1'b1;  exp_s[1] = 1'b0;  exp_s[2] = 1'b0;
        op = 3'b111; in1 = 8'h81; mode = 2'b01; en = 1'b1;
        tick();
        mode = 2'b10; ser_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q !== exp_q[i] || ser_out !== exp_s[i]) begin
                failures++;
                $display("FAIL shl%0d got=%h/%b exp=%h/%b",
                         i, q, ser_out, exp_q[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_shift_right_gate();
        op = 3'b111; in1 = 8'h81; mode = 2'b01; en = 1'b1;
        tick();
        mode = 2'b11; ser_in = 1'b0;
        tick();
        checks++;
        if (q !== 8'h40 || ser_out !== 1'b1) begin
            failures++;
            $display("FAIL shr got=%h/%b exp=40/1", q, ser_out);
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (q !== 8'h40 || ser_out !== 1'b1) begin
                failures++;
                $display("FAIL en_hold%0d got=%h/%b exp=40/1", i, q, ser_out);
            end
        end
    endtask

    task automatic test_delay_line();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22;
        exp_d[2] = 8'h33; exp_d[3] = 8'h33;
        op = 3'b111; mode = 2'b01; en = 1'b1;
        in1 = 8'h11; tick();
        in1 = 8'h22; tick();
        in1 = 8'h33; tick();
        checks++;
        if (q !== 8'h33) begin
            failures++;
            $display("FAIL dly_q got=%h exp=33", q);
        end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_dly !== exp_d[i]) begin
                failures++;
                $display("FAIL dly%0d got=%h exp=%h", i, q_dly, exp_d[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        op = 3'b111; in1 = 8'h81; mode = 2'b01; en = 1'b1;
        tick();
        mode = 2'b10; ser_in = 1'b1;
        tick();
        checks++;
        if (q !== 8'h03 || ser_out !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre got=%h/%b exp=03/1", q, ser_out);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (q !== 8'h00 || q_dly !== 8'h00 || ser_out !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst got=%h/%h/%b exp=00/00/0",
                     q, q_dly, ser_out);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (q !== 8'h01 || q_dly !== 8'h00 || ser_out !== 1'b0) begin
            failures++;
            $display("FAIL mid_resume got=%h/%h/%b exp=01/00/0",
                     q, q_dly, ser_out);
        end
    endtask

    initial begin
        rst = 1'b0; in1 = '0; in2 = '0; op = '0;
        mode = '0; en = 1'b0; ser_in = 1'b0;
        test_reset();
        test_op_sweep();
        test_shift_left();
        test_shift_right_gate();
        test_delay_line();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_shift_reg.md
Name: logic_shift_reg

Overview:
- Parametrised successor to the team's basic gates plus D flip-flop block.
- Provides a WIDTH-bit selectable logic unit feeding a WIDTH-bit register with hold, load, shift-left and shift-right modes.
- Adds a STAGES-deep delayed copy of the register, a serial shift-out bit and a zero flag.
- Sits in the lab datapath as the reusable gate/flop primitive for later bit-manipulation blocks.

Parameters:
- WIDTH, 8: operand, register and delay-line width; legal range 2 or more.
- STAGES, 2: delay-line depth in clock cycles; legal range 1 or more.

Ports:
- clk  input  1  rising-edge clock; sole clock of the block.
- rst  input  1  synchronous active-low reset, sampled on rising clk.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- op  input  3  logic function select.
- mode  input  2  register mode select.
- en  input  1  register update enable.
- ser_in  input  1  serial fill bit for shift modes.
- out1  output  WIDTH  combinational in1 XOR in2.
- out2  output  WIDTH  combinational out1 AND in2.
- f  output  WIDTH  combinational logic-unit result.
- q  output  WIDTH  main register.
- q_dly  output  WIDTH  q delayed by STAGES cycles.
- ser_out  output  1  last bit shifted out.
- zero  output  1  combinational, 1 when q is all zeros.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low: rst=0 sampled at a rising clk edge resets the block; no asynchronous path.
- Reset values: q=0, every delay stage=0 (so q_dly=0), ser_out=0, zero=1.
- Reset priority: reset overrides en, mode and all other inputs. Reset asserted mid-shift clears state on that edge; no partial update.
- Logic unit f, selected by op:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NAND
  - 100 NOR
  - 101 XNOR
  - 110 NOT in1
  - 111 pass in1
- Logic unit is purely bitwise at WIDTH bits; no carry.
- Register update, when rst=1 and en=1, by mode:
  - 00 hold.
  - 01 load: q<=f.
  - 10 shift left: q<={q[WIDTH-2:0],ser_in}, ser_out<=q[WIDTH-1].
  - 11 shift right: q<={ser_in,q[WIDTH-1:1]}, ser_out<=q[0].
- When en=0, q and ser_out hold regardless of mode.
- ser_out changes only on shift edges. It holds its value in modes 00 and 01.
- Latency:
  - f, out1, out2: 0 cycles.
  - q: 1 cycle after the sampling edge.
  - q_dly: equals q from STAGES cycles earlier.
- Delay line advances every clock edge and is not gated by en.
- Delay-line boundary: with STAGES=1, q_dly is q registered once more.
- Shift wrap: the bit shifted out is lost from q; only ser_out retains it. There is no rotate mode; rotate is done by feeding ser_out back into ser_in externally.
- No X propagation: all registers are defined after the first reset edge.

Decomposition:
- Shared package logic_shift_pkg holds:
  - op encodings: OP_AND through OP_PASS.
  - mode encodings: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR.
- One natural sub-module: logic_fn, a combinational WIDTH-parametrised op decoder producing f.
- The register, delay line and flags stay in the top module.

Test Plan (WIDTH=8, STAGES=2):
- Reset: hold rst=0 for 2 edges with en=1, mode=01, in1=FF -> q=00, q_dly=00, ser_out=0, zero=1. rst=1 next edge -> q=FF, zero=0.
- Op sweep: in1=C3, in2=A5, all 8 op values, mode=01, en=1 -> q after 1 edge:
  - AND 81, OR E7, XOR 66, NAND 7E, NOR 18, XNOR 99, NOT 3C, PASS C3.
  - out1=66, out2=24 throughout.
- Shift left: load 81, then mode=10, ser_in=1 for 3 edges -> q = 03, 07, 0F; ser_out = 1, 0, 0.
- Shift right plus enable gating: load 81, mode=11, ser_in=0, then:
  - 1 edge -> q=40, ser_out=1.
  - en=0 for 2 edges -> q=40, ser_out=1 unchanged.
- Delay line: load sequence 11, 22, 33 on consecutive edges -> q_dly shows 11, 22, 33 exactly 2 edges after q does. With en=0 after that, q_dly settles to 33.
- Reset mid-operation: during a shift-left stream, drive rst=0 for 1 edge -> q, q_dly and ser_out all 0 on that edge. Shifting resumes from 00 next edge.
